// File: rtl/ft600_tx_arbiter.sv
// ft600_tx_arbiter
//   Merges two byte streams (A, B) into FT600 transmit packets. One channel at
//   a time owns the packet buffer (round-robin). Received bytes are packed after
//   a one-byte header. The packet is handed to the FT600 once it is complete:
//   the owner signalled end-of-message, the payload is full, or the owner went
//   quiet for TIMEOUT cycles.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   a_data/valid/last    channel A byte stream, a_ready = byte accepted
//   b_data/valid/last    channel B byte stream, b_ready = byte accepted
//   tx_buf               packet image, byte k at [8k+7:8k], byte 0 = header
//   tx_buf_send          byte count to transmit (0 = no request)
//   tx_buf_sent          completion echo from the FT600 side
//   grant                one-hot owner {B,A}, 00 = none
//   busy                 high whenever a packet is in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner; arbitrate on the valids, buffer/counters cleared
// COLLECT  | granted channel is streaming bytes into tx_buf
// SEND     | tx_buf_send = cnt+1, waiting for a matching tx_buf_sent echo
// WAIT_CLR | request dropped, waiting for tx_buf_sent to return to 0
module ft600_tx_arbiter #(
  parameter int TX_BUFFER   = 16,
  parameter int MAX_PAYLOAD = 14,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             a_data,
  input  logic                   a_valid,
  input  logic                   a_last,
  output logic                   a_ready,
  input  logic [7:0]             b_data,
  input  logic                   b_valid,
  input  logic                   b_last,
  output logic                   b_ready,
  output logic [8*TX_BUFFER-1:0] tx_buf,
  output logic [3:0]             tx_buf_send,
  input  logic [3:0]             tx_buf_sent,
  output logic [1:0]             grant,
  output logic                   busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] WAIT_CLR = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(8 * TX_BUFFER);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_HIT = TW'(TIMEOUT - 1);
  localparam logic [3:0]    CNT_MAX   = 4'(MAX_PAYLOAD);

  logic [1:0]    state;
  logic          owner;     // 0 = A, 1 = B
  logic          pref_b;    // round-robin: B wins a tie when set
  logic [3:0]    cnt;
  logic [TW-1:0] timer;

  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          accept;
  logic          timer_hit;
  logic          win_b;
  logic [3:0]    cnt_inc;
  logic [IW-1:0] wr_lsb;

  assign a_ready = (state == COLLECT) && grant[0];
  assign b_ready = (state == COLLECT) && grant[1];
  assign busy    = (state != IDLE);

  always_comb begin
    sel_valid = owner ? b_valid : a_valid;
    sel_last  = owner ? b_last  : a_last;
    sel_data  = owner ? b_data  : a_data;
    // ready is asserted for the owner throughout COLLECT, so valid alone accepts
    accept    = (state == COLLECT) && sel_valid;
    cnt_inc   = cnt + 4'd1;
    wr_lsb    = IW'({cnt_inc, 3'b000});
    // this idle cycle is the one that brings the timer up to TIMEOUT
    timer_hit = (timer >= TIMER_HIT);
    win_b     = b_valid && (!a_valid || pref_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      pref_b      <= 1'b0;
      cnt         <= '0;
      timer       <= '0;
      tx_buf      <= '0;
      tx_buf_send <= '0;
      grant       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          cnt         <= '0;
          timer       <= '0;
          tx_buf      <= '0;
          tx_buf_send <= '0;
          if (a_valid || b_valid) begin
            owner <= win_b;
            grant <= win_b ? 2'b10 : 2'b01;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (accept) begin
            tx_buf[wr_lsb +: 8] <= sel_data;
            cnt                 <= cnt_inc;
            timer               <= '0;
            if (sel_last || (cnt_inc == CNT_MAX)) begin
              tx_buf[7:0] <= {owner, 3'b000, cnt_inc};
              tx_buf_send <= cnt_inc + 4'd1;
              state       <= SEND;
            end
          end else begin
            if (timer != TIMER_MAX) timer <= timer + TW'(1);
            if (timer_hit) begin
              if (cnt != 4'd0) begin
                tx_buf[7:0] <= {owner, 3'b000, cnt};
                tx_buf_send <= cnt_inc;
                state       <= SEND;
              end else begin
                // nothing collected: release the grant, but still rotate priority
                grant  <= 2'b00;
                pref_b <= ~owner;
                state  <= IDLE;
              end
            end
          end
        end

        SEND: begin
          if (tx_buf_sent == tx_buf_send) begin
            tx_buf_send <= '0;
            state       <= WAIT_CLR;
          end
        end

        WAIT_CLR: begin
          if (tx_buf_sent == 4'd0) begin
            grant  <= 2'b00;
            pref_b <= ~owner;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Testbench for ft600_tx_arbiter: a directed vector table, hand-written
// sequences for the multi-cycle corner cases, and a randomized run checked
// against a packet-level reference model.
module tb_ft600_tx_arbiter;

  localparam int TXB  = 16;
  localparam int MAXP = 14;
  localparam int TO   = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     a_data, b_data;
  logic           a_valid, a_last, a_ready;
  logic           b_valid, b_last, b_ready;
  logic [8*TXB-1:0] tx_buf;
  logic [3:0]     tx_buf_send, tx_buf_sent;
  logic [1:0]     grant;
  logic           busy;

  ft600_tx_arbiter #(.TX_BUFFER(TXB), .MAX_PAYLOAD(MAXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .tx_buf(tx_buf), .tx_buf_send(tx_buf_send), .tx_buf_sent(tx_buf_sent),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 0; a_last = 0; a_data = 8'h00;
    b_valid = 0; b_last = 0; b_data = 8'h00;
    tx_buf_sent = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A sends A1,A2,A3 (last on A3); returns right after the edge that enters SEND
  task automatic a_packet3();
    a_valid = 1; a_data = 8'hA1; a_last = 0;
    tick();
    tick();
    a_data = 8'hA2;
    tick();
    a_data = 8'hA3; a_last = 1;
    tick();
    a_valid = 0; a_last = 0;
  endtask

  typedef struct {
    logic av, al; logic [7:0] ad;
    logic bv, bl; logic [7:0] bd;
    logic [3:0] sent;
    logic [1:0] g; logic ar, br, bsy;
    logic [3:0] snd; logic [31:0] lo;
  } vec_t;
  vec_t tbl[14];

  // ---------------- reference model (packet level) ----------------
  int         m_own;      // -1 none, 0 A, 1 B
  int         m_pref_b;
  logic [7:0] m_q[$];
  int         m_idle;
  bit         m_closed, m_echoed;

  task automatic m_reset();
    m_own = -1; m_pref_b = 0; m_q.delete(); m_idle = 0; m_closed = 0; m_echoed = 0;
  endtask

  task automatic m_step(input logic av, input logic al, input logic [7:0] ad,
                        input logic bv, input logic bl, input logic [7:0] bd,
                        input logic [3:0] sent);
    logic cv, cl; logic [7:0] cd;
    if (m_own < 0) begin
      if (av || bv) begin
        m_own = (av && bv) ? m_pref_b : (bv ? 1 : 0);
        m_q.delete(); m_idle = 0; m_closed = 0; m_echoed = 0;
      end
    end else if (!m_closed) begin
      cv = (m_own == 1) ? bv : av;
      cl = (m_own == 1) ? bl : al;
      cd = (m_own == 1) ? bd : ad;
      if (cv) begin
        m_q.push_back(cd);
        m_idle = 0;
        if (cl || m_q.size() == MAXP) m_closed = 1;
      end else begin
        if (m_idle < TO) m_idle++;
        if (m_idle == TO) begin
          if (m_q.size() > 0) m_closed = 1;
          else begin m_pref_b = (m_own == 0) ? 1 : 0; m_own = -1; end
        end
      end
    end else if (!m_echoed) begin
      if (int'(sent) == m_q.size() + 1) m_echoed = 1;
    end else if (sent == 4'd0) begin
      m_pref_b = (m_own == 0) ? 1 : 0;
      m_own = -1;
    end
  endtask

  function automatic logic [127:0] m_buf();
    logic [127:0] b;
    b = '0;
    b[7:0] = {(m_own == 1), 3'b000, 4'(m_q.size())};
    for (int k = 0; k < m_q.size(); k++) b[8*(k+1) +: 8] = m_q[k];
    return b;
  endfunction

  // ---------------- test sequence ----------------
  int nb, w, ng, quiet;
  logic acc;
  logic [127:0] e_buf;
  logic [1:0] got[4];
  logic [1:0] prev_g;
  logic [3:0] prev_snd, e_snd;
  logic [1:0] e_g;
  logic av, al, bv, bl;
  logic [7:0] ad, bd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // av al ad   bv bl bd   sent | grant ar br busy send buf[31:0]
    tbl[0]  = '{1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00, 4'd0, 2'b01,1'b1,1'b0,1'b1,4'd0,32'h00000000};
    tbl[1]  = '{1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00, 4'd0, 2'b01,1'b1,1'b0,1'b1,4'd0,32'h00001100};
    tbl[2]  = '{1'b1,1'b0,8'h22, 1'b0,1'b0,8'h00, 4'd0, 2'b01,1'b1,1'b0,1'b1,4'd0,32'h00221100};
    tbl[3]  = '{1'b1,1'b1,8'h33, 1'b1,1'b1,8'h77, 4'd0, 2'b01,1'b0,1'b0,1'b1,4'd4,32'h33221103};
    tbl[4]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd0, 2'b01,1'b0,1'b0,1'b1,4'd4,32'h33221103};
    tbl[5]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd4, 2'b01,1'b0,1'b0,1'b1,4'd0,32'h33221103};
    tbl[6]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd4, 2'b01,1'b0,1'b0,1'b1,4'd0,32'h33221103};
    tbl[7]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd0, 2'b00,1'b0,1'b0,1'b0,4'd0,32'h33221103};
    tbl[8]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd0, 2'b00,1'b0,1'b0,1'b0,4'd0,32'h00000000};
    tbl[9]  = '{1'b1,1'b0,8'h44, 1'b1,1'b0,8'h5A, 4'd0, 2'b10,1'b0,1'b1,1'b1,4'd0,32'h00000000};
    tbl[10] = '{1'b1,1'b1,8'h44, 1'b1,1'b1,8'h5A, 4'd0, 2'b10,1'b0,1'b0,1'b1,4'd2,32'h00005A81};
    tbl[11] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd2, 2'b10,1'b0,1'b0,1'b1,4'd0,32'h00005A81};
    tbl[12] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 4'd0, 2'b00,1'b0,1'b0,1'b0,4'd0,32'h00005A81};
    tbl[13] = '{1'b1,1'b0,8'h66, 1'b1,1'b0,8'h77, 4'd0, 2'b01,1'b1,1'b0,1'b1,4'd0,32'h00000000};

    // reset state
    do_reset();
    chk("reset_buf", tx_buf, 128'd0);
    chk("reset_ctl", 128'({grant, busy, a_ready, b_ready, tx_buf_send}), 128'd0);

    // directed table: A packet, echo handshake, B wins tie, A wins next tie
    for (int i = 0; i < 14; i++) begin
      a_valid = tbl[i].av; a_last = tbl[i].al; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_last = tbl[i].bl; b_data = tbl[i].bd;
      tx_buf_sent = tbl[i].sent;
      tick();
      chk($sformatf("tbl%0d_grant", i), 128'(grant), 128'(tbl[i].g));
      chk($sformatf("tbl%0d_ready", i), 128'({a_ready, b_ready}), 128'({tbl[i].ar, tbl[i].br}));
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].bsy));
      chk($sformatf("tbl%0d_send", i), 128'(tx_buf_send), 128'(tbl[i].snd));
      chk($sformatf("tbl%0d_buf", i), 128'(tx_buf[31:0]), 128'(tbl[i].lo));
    end

    // B streams 20 bytes without last: full packet then timeout flush
    do_reset();
    b_valid = 1; b_data = 8'd1; nb = 0;
    for (int c = 0; c < 60 && nb < 14; c++) begin
      acc = b_ready;
      tick();
      if (acc) begin nb++; b_data = 8'(nb + 1); end
    end
    chk("stream_p1_count", 128'(nb), 128'd14);
    e_buf = '0; e_buf[7:0] = 8'h8E;
    for (int k = 1; k <= 14; k++) e_buf[8*k +: 8] = 8'(k);
    chk("stream_p1_send", 128'(tx_buf_send), 128'd15);
    chk("stream_p1_buf", tx_buf, e_buf);
    tx_buf_sent = 4'd15; tick();
    chk("stream_p1_clr", 128'(tx_buf_send), 128'd0);
    tx_buf_sent = 4'd0; tick();
    chk("stream_idle_busy", 128'(busy), 128'd0);
    for (int c = 0; c < 60 && nb < 20; c++) begin
      acc = b_ready;
      tick();
      if (acc) begin
        nb++; b_data = 8'(nb + 1);
        if (nb == 20) b_valid = 0;
      end
    end
    chk("stream_p2_count", 128'(nb), 128'd20);
    w = 0;
    while (tx_buf_send == 4'd0 && w < 400) begin tick(); w++; end
    chk("stream_flush_latency", 128'(w), 128'(TO));
    e_buf = '0; e_buf[7:0] = 8'h86;
    for (int k = 1; k <= 6; k++) e_buf[8*k +: 8] = 8'(14 + k);
    chk("stream_p2_send", 128'(tx_buf_send), 128'd7);
    chk("stream_p2_buf", tx_buf, e_buf);
    tx_buf_sent = 4'd7; tick(); tx_buf_sent = 4'd0; tick();

    // both channels continuously valid: alternating grants
    do_reset();
    a_valid = 1; b_valid = 1; prev_g = 2'b00; prev_snd = 4'd0; ng = 0;
    for (int k = 0; k < 4; k++) got[k] = 2'b00;
    for (int c = 0; c < 300 && ng < 4; c++) begin
      tx_buf_sent = tx_buf_send;
      a_data = 8'($urandom); b_data = 8'($urandom);
      tick();
      if (prev_g == 2'b00 && grant != 2'b00) begin got[ng] = grant; ng++; end
      if (prev_snd == 4'd0 && tx_buf_send != 4'd0)
        chk("rr_packet_send", 128'(tx_buf_send), 128'd15);
      prev_g = grant; prev_snd = tx_buf_send;
    end
    chk("rr_grant_count", 128'(ng), 128'd4);
    chk("rr_grant0", 128'(got[0]), 128'(2'b01));
    chk("rr_grant1", 128'(got[1]), 128'(2'b10));
    chk("rr_grant2", 128'(got[2]), 128'(2'b01));
    chk("rr_grant3", 128'(got[3]), 128'(2'b10));

    // a_valid pulse: empty timeout, then B preferred
    do_reset();
    a_valid = 1; tick(); a_valid = 0;
    w = (grant == 2'b01) ? 1 : 0;
    nb = (tx_buf_send != 4'd0) ? 1 : 0;
    for (int c = 0; c < 400 && grant == 2'b01; c++) begin
      tick();
      if (tx_buf_send != 4'd0) nb++;
      if (grant == 2'b01) w++;
    end
    chk("empty_timeout_cycles", 128'(w), 128'(TO));
    chk("empty_timeout_nosend", 128'(nb), 128'd0);
    chk("empty_timeout_idle", 128'({grant, busy}), 128'd0);
    a_valid = 1; b_valid = 1; tick();
    chk("empty_timeout_next_b", 128'(grant), 128'(2'b10));
    a_valid = 0; b_valid = 0;

    // mismatching echo ignored in SEND
    do_reset();
    a_packet3();
    e_buf = '0; e_buf[31:0] = 32'hA3A2A103;
    chk("send_hold_start", 128'(tx_buf_send), 128'd4);
    tx_buf_sent = 4'd2;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("send_hold%0d_send", c), 128'(tx_buf_send), 128'd4);
      chk($sformatf("send_hold%0d_buf", c), tx_buf, e_buf);
    end
    tx_buf_sent = 4'd4; tick();
    chk("send_match_clr", 128'({busy, grant, tx_buf_send}), 128'({1'b1, 2'b01, 4'd0}));
    tx_buf_sent = 4'd0; tick();
    chk("send_match_idle", 128'({busy, grant}), 128'd0);

    // reset asserted during SEND
    do_reset();
    a_packet3();
    #2 rst_n = 1'b0;
    #1;
    chk("midsend_reset_buf", tx_buf, 128'd0);
    chk("midsend_reset_ctl", 128'({grant, busy, a_ready, b_ready, tx_buf_send}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1; a_data = 8'h5C;
    tick();
    chk("midsend_regrant", 128'({grant, a_ready, tx_buf_send}), 128'({2'b01, 1'b1, 4'd0}));
    chk("midsend_regrant_buf", tx_buf, 128'd0);

    // randomized run against the reference model
    do_reset();
    m_reset();
    quiet = 0;
    for (int c = 0; c < 8000; c++) begin
      if (quiet > 0) begin
        quiet--; av = 0; bv = 0;
      end else begin
        if ($urandom_range(0, 299) == 0) quiet = $urandom_range(200, 300);
        av = ($urandom_range(0, 9) < 6);
        bv = ($urandom_range(0, 9) < 6);
      end
      al = ($urandom_range(0, 7) == 0);
      bl = ($urandom_range(0, 7) == 0);
      ad = 8'($urandom); bd = 8'($urandom);
      if (tx_buf_send != 4'd0)
        tx_buf_sent = ($urandom_range(0, 2) == 0) ? tx_buf_send : 4'($urandom_range(0, 15));
      else if (tx_buf_sent != 4'd0)
        tx_buf_sent = ($urandom_range(0, 1) == 0) ? 4'd0 : tx_buf_sent;
      a_valid = av; a_last = al; a_data = ad;
      b_valid = bv; b_last = bl; b_data = bd;
      m_step(av, al, ad, bv, bl, bd, tx_buf_sent);
      tick();
      e_g   = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
      e_snd = (m_closed && !m_echoed) ? 4'(m_q.size() + 1) : 4'd0;
      chk($sformatf("rand%0d_ctl", c),
          128'({grant, a_ready, b_ready, busy, tx_buf_send}),
          128'({e_g, (m_own == 0) && !m_closed, (m_own == 1) && !m_closed, m_own >= 0, e_snd}));
      if (e_snd != 4'd0) chk($sformatf("rand%0d_buf", c), tx_buf, m_buf());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
